// File: rtl/piano_pkg.sv
// Shared definitions for the keyboard front end and the tone divider bank.
//   N_KEYS    default number of keys/notes
//   TICK_DIV  default debounce sample prescaler period (clk cycles)
//   DB_COUNT  default number of consecutive mismatching ticks to accept a key
//   chord_t   one bit per note, 1 = key held
package piano_pkg;

  localparam int unsigned N_KEYS   = 8;
  localparam int unsigned TICK_DIV = 50000;
  localparam int unsigned DB_COUNT = 8;

  typedef logic [N_KEYS-1:0] chord_t;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

endpackage

// File: rtl/key_debounce_cell.sv
// Single-key debouncer: accepts a new key level after DB_COUNT consecutive
// sample ticks of mismatch, emitting registered press/release pulses.
//   clk, rst   clock, async active-high reset
//   s          synchronised key level
//   tick       shared sample strobe (one clk cycle wide)
//   chord      debounced key level (registered)
//   press      one-cycle pulse on accepted 0->1 (registered)
//   released   one-cycle pulse on accepted 1->0 (registered)
//   toggle_c   combinational: chord flips on the next edge
module key_debounce_cell #(
  parameter int unsigned DB_COUNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic tick,
  output logic chord,
  output logic press,
  output logic released,
  output logic toggle_c
);

  import piano_pkg::*;

  localparam int unsigned CW = $clog2(DB_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          mismatch;

  assign mismatch = s ^ chord;

  // State register plus debounced level and event flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_STABLE;
      cnt      <= '0;
      chord    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      chord    <= chord ^ toggle_c;
      press    <= toggle_c & ~chord;
      released <= toggle_c & chord;
    end
  end

  // Next-state: any agreeing cycle while pending restarts the count
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    toggle_c = 1'b0;
    case (state)
      ST_STABLE: begin
        cnt_n = '0;
        if (mismatch && tick) begin
          if (DB_COUNT == 1) begin
            toggle_c = 1'b1;
          end else begin
            cnt_n   = CW'(1);
            state_n = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        if (!mismatch) begin
          cnt_n   = '0;
          state_n = ST_STABLE;
        end else if (tick) begin
          if (cnt == CNT_LAST) begin
            toggle_c = 1'b1;
            cnt_n    = '0;
            state_n  = ST_STABLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_STABLE;
      end
    endcase
  end

endmodule

// File: rtl/chord_scan.sv
// Debounced keyboard front end producing the held-key chord vector.
//   clk        system clock
//   rst        async active-high reset
//   key_in     raw asynchronous key contacts
//   chord      debounced held-key vector (1 = down)
//   press      per-key one-cycle pulse on accepted press
//   released   per-key one-cycle pulse on accepted release
//   changed    one-cycle pulse when any key press/release is accepted
module chord_scan #(
  parameter int unsigned N_KEYS         = piano_pkg::N_KEYS,
  parameter int unsigned TICK_DIV       = piano_pkg::TICK_DIV,
  parameter int unsigned DB_COUNT       = piano_pkg::DB_COUNT,
  parameter int unsigned KEY_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] chord,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] released,
  output logic              changed
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_KEYS-1:0] k;
  logic [N_KEYS-1:0] sync1, s;
  logic [TW-1:0]     presc;
  logic              tick;
  logic [N_KEYS-1:0] toggle;

  assign k    = (KEY_ACTIVE_LOW != 0) ? ~key_in : key_in;
  assign tick = (presc == TICK_LAST);

  // Two-flop synchroniser, prescaler and aggregated event flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      s       <= '0;
      presc   <= '0;
      changed <= 1'b0;
    end else begin
      sync1   <= k;
      s       <= sync1;
      presc   <= tick ? '0 : presc + TW'(1);
      changed <= |toggle;
    end
  end

  // One independent debouncer per key
  for (genvar i = 0; i < int'(N_KEYS); i++) begin : g_key
    key_debounce_cell #(
      .DB_COUNT(DB_COUNT)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .s        (s[i]),
      .tick     (tick),
      .chord    (chord[i]),
      .press    (press[i]),
      .released (released[i]),
      .toggle_c (toggle[i])
    );
  end

endmodule

// File: tb/tb_chord_scan.sv
// Directed bench for chord_scan with a scoreboard of expected key events.
module tb_chord_scan;

  localparam int unsigned NK  = 8;
  localparam int          LO  = 11;  // (DB_COUNT-1)*TICK_DIV+3
  localparam int          HI  = 14;  // DB_COUNT*TICK_DIV+2

  typedef struct {
    logic [NK-1:0] chord;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_in, key_in_al;
  logic [NK-1:0] chord, press, released;
  logic [NK-1:0] chord_al, press_al, released_al;
  logic          changed, changed_al;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  chord_scan #(.N_KEYS(NK), .TICK_DIV(4), .DB_COUNT(3), .KEY_ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .chord(chord), .press(press), .released(released), .changed(changed)
  );

  chord_scan #(.N_KEYS(NK), .TICK_DIV(4), .DB_COUNT(3), .KEY_ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .key_in(key_in_al),
    .chord(chord_al), .press(press_al), .released(released_al), .changed(changed_al)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [NK-1:0] c, input logic [NK-1:0] p, input logic [NK-1:0] r);
    exp_t e;
    e.chord = c;
    e.press = p;
    e.rel   = r;
    sb.push_back(e);
  endtask

  // Wait (bounded) for the next accepted event, compare with scoreboard head
  task automatic expect_event(input string tag, input int lo, input int hi);
    exp_t e;
    int   n;
    bit   seen;
    e    = sb.pop_front();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < hi + 2) begin
      cycle();
      n++;
      if (changed === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen && n >= lo && n <= hi) else begin
      errors++;
      $error("FAIL %s_latency: got %0d cycles (seen=%0d) exp %0d..%0d", tag, n, seen, lo, hi);
    end
    check({tag, "_chord"},   32'(chord),    32'(e.chord));
    check({tag, "_press"},   32'(press),    32'(e.press));
    check({tag, "_release"}, 32'(released), 32'(e.rel));
    cycle();
    check({tag, "_press_w"},   32'(press),    32'h0);
    check({tag, "_release_w"}, 32'(released), 32'h0);
    check({tag, "_changed_w"}, 32'(changed),  32'h0);
    check({tag, "_chord_h"},   32'(chord),    32'(e.chord));
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   seen;

    rst       = 1'b1;
    key_in    = '0;
    key_in_al = 8'hFF;
    repeat (3) cycle();
    check("rst_chord",    32'(chord),    32'h0);
    check("rst_press",    32'(press),    32'h0);
    check("rst_release",  32'(released), 32'h0);
    check("rst_changed",  32'(changed),  32'h0);
    check("rst_chord_al", 32'(chord_al), 32'h0);
    rst = 1'b0;
    repeat (2) cycle();

    // Clean press, release, simultaneous two-key press and release
    key_in = 8'h04; push(8'h04, 8'h04, 8'h00); expect_event("press04", LO, HI);
    key_in = 8'h00; push(8'h00, 8'h00, 8'h04); expect_event("rel04", LO, HI);
    key_in = 8'h81; push(8'h81, 8'h81, 8'h00); expect_event("press81", LO, HI);
    key_in = 8'h00; push(8'h00, 8'h00, 8'h81); expect_event("rel81", LO, HI);

    // Bounce on bit 2: 5-cycle segments never see 3 ticks of mismatch
    for (int seg = 0; seg < 8; seg++) begin
      key_in = (seg % 2 == 0) ? 8'h04 : 8'h00;
      for (int c = 0; c < 5; c++) begin
        cycle();
        check("bounce_changed", 32'(changed), 32'h0);
        check("bounce_chord",   32'(chord),   32'h0);
      end
    end
    key_in = 8'h04; push(8'h04, 8'h04, 8'h00); expect_event("bounce_hold", LO, HI);

    // Reset while key 4 is pending; chord must clear at once
    key_in = 8'h14;
    repeat (6) begin
      cycle();
      check("pend_changed", 32'(changed), 32'h0);
    end
    rst = 1'b1;
    #1;
    check("midrst_chord",   32'(chord),    32'h0);
    check("midrst_press",   32'(press),    32'h0);
    check("midrst_release", 32'(released), 32'h0);
    check("midrst_changed", 32'(changed),  32'h0);
    cycle();
    rst = 1'b0;
    push(8'h14, 8'h14, 8'h00);
    expect_event("after_rst", LO, HI);

    // Active-low instance: only key 0 pulled low
    key_in_al = 8'hFE;
    e.chord = 8'h01; e.press = 8'h01; e.rel = 8'h00;
    sb.push_back(e);
    e = sb.pop_front();
    n = 0;
    seen = 1'b0;
    while (!seen && n < HI + 2) begin
      cycle();
      n++;
      if (changed_al === 1'b1) seen = 1'b1;
    end
    check("al_seen",    32'(seen),        32'h1);
    check("al_chord",   32'(chord_al),    32'(e.chord));
    check("al_press",   32'(press_al),    32'(e.press));
    check("al_release", 32'(released_al), 32'(e.rel));
    cycle();
    check("al_press_w", 32'(press_al), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
